// File: rtl/obsidian_memory_stage.sv
// obsidian_memory_stage: pipeline MEM stage with a multi-cycle data-memory req/ready handshake.
// Optional BUSY watchdog and timeout_err port are enabled by defining OBSIDIAN_MEM_TIMEOUT_EN.
module obsidian_memory_stage
#(
    parameter int unsigned MEM_TIMEOUT_CYCLES = 16
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic [106:0] EX_MEM,
    output logic [70:0]  MEM_WB,
    output logic         stall,
    output logic         pcsrc,
    output logic [31:0]  branch_target,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_ready,
    output logic         align_err
`ifdef OBSIDIAN_MEM_TIMEOUT_EN
   ,output logic         timeout_err
`endif
);

    // state | meaning
    // IDLE  | EX_MEM sampled every edge
    // BUSY  | request outstanding, waiting on mem_ready
    // DONE  | access result written to MEM_WB, stall released
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    logic        ex_regwrite;
    logic        ex_memtoreg;
    logic        ex_branch;
    logic        ex_memread;
    logic        ex_memwrite;
    logic [31:0] ex_target;
    logic        ex_zero;
    logic [31:0] ex_alu;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;

    assign ex_regwrite = EX_MEM[106];
    assign ex_memtoreg = EX_MEM[105];
    assign ex_branch   = EX_MEM[104];
    assign ex_memread  = EX_MEM[103];
    assign ex_memwrite = EX_MEM[102];
    assign ex_target   = EX_MEM[101:70];
    assign ex_zero     = EX_MEM[69];
    assign ex_alu      = EX_MEM[68:37];
    assign ex_wdata    = EX_MEM[36:5];
    assign ex_rd       = EX_MEM[4:0];

    state_t      state_q, state_d;
    logic [70:0] mem_wb_q, mem_wb_d;
    logic        pcsrc_q, pcsrc_d;
    logic [31:0] branch_target_q, branch_target_d;
    logic        align_err_q, align_err_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        cap_regwrite_q, cap_regwrite_d;
    logic        cap_memtoreg_q, cap_memtoreg_d;
    logic        cap_read_q, cap_read_d;
    logic [4:0]  cap_rd_q, cap_rd_d;
    logic [31:0] rdata_q, rdata_d;

`ifdef OBSIDIAN_MEM_TIMEOUT_EN
    localparam logic [4:0] TMO_LAST = 5'(MEM_TIMEOUT_CYCLES - 1);

    logic [4:0] tmo_cnt_q, tmo_cnt_d;
    logic       timeout_err_q, timeout_err_d;
`endif

    logic ex_is_mem;
    logic ex_misaligned;

    assign ex_is_mem     = ex_memread | ex_memwrite;
    assign ex_misaligned = ex_is_mem & (ex_alu[1:0] != 2'b00);

    always_comb begin
        state_d         = state_q;
        mem_wb_d        = mem_wb_q;
        pcsrc_d         = 1'b0;
        branch_target_d = branch_target_q;
        align_err_d     = 1'b0;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        cap_regwrite_d  = cap_regwrite_q;
        cap_memtoreg_d  = cap_memtoreg_q;
        cap_read_d      = cap_read_q;
        cap_rd_d        = cap_rd_q;
        rdata_d         = rdata_q;
`ifdef OBSIDIAN_MEM_TIMEOUT_EN
        tmo_cnt_d       = tmo_cnt_q;
        timeout_err_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                pcsrc_d         = ex_branch & ex_zero;
                branch_target_d = ex_target;
                if (!ex_is_mem) begin
                    mem_wb_d = {ex_regwrite, ex_memtoreg, 32'h0, ex_alu, ex_rd};
                end else if (ex_misaligned) begin
                    align_err_d = 1'b1;
                    mem_wb_d    = {1'b0, ex_memtoreg, 32'h0, ex_alu, ex_rd};
                end else begin
                    mem_we_d       = ex_memwrite;
                    mem_addr_d     = ex_alu;
                    mem_wdata_d    = ex_wdata;
                    cap_regwrite_d = ex_regwrite;
                    cap_memtoreg_d = ex_memtoreg;
                    // read+write together behaves as a write, so no load data is kept
                    cap_read_d     = ex_memread & ~ex_memwrite;
                    cap_rd_d       = ex_rd;
                    mem_wb_d[70]   = 1'b0;
                    state_d        = BUSY;
`ifdef OBSIDIAN_MEM_TIMEOUT_EN
                    tmo_cnt_d      = 5'd0;
`endif
                end
            end

            BUSY: begin
                if (mem_ready) begin
                    rdata_d = cap_read_q ? mem_rdata : 32'h0;
                    state_d = DONE;
                end
`ifdef OBSIDIAN_MEM_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    rdata_d        = 32'hDEAD_BEEF;
                    cap_regwrite_d = 1'b0;
                    timeout_err_d  = 1'b1;
                    state_d        = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 5'd1;
                end
`endif
            end

            DONE: begin
                mem_wb_d = {cap_regwrite_q, cap_memtoreg_q, rdata_q, mem_addr_q, cap_rd_q};
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            mem_wb_q        <= 71'h0;
            pcsrc_q         <= 1'b0;
            branch_target_q <= 32'h0;
            align_err_q     <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= 32'h0;
            mem_wdata_q     <= 32'h0;
            cap_regwrite_q  <= 1'b0;
            cap_memtoreg_q  <= 1'b0;
            cap_read_q      <= 1'b0;
            cap_rd_q        <= 5'h0;
            rdata_q         <= 32'h0;
        end else begin
            state_q         <= state_d;
            mem_wb_q        <= mem_wb_d;
            pcsrc_q         <= pcsrc_d;
            branch_target_q <= branch_target_d;
            align_err_q     <= align_err_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            cap_regwrite_q  <= cap_regwrite_d;
            cap_memtoreg_q  <= cap_memtoreg_d;
            cap_read_q      <= cap_read_d;
            cap_rd_q        <= cap_rd_d;
            rdata_q         <= rdata_d;
        end
    end

`ifdef OBSIDIAN_MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q     <= 5'd0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

    // req/stall follow the state so a reset clears them on the same edge
    assign stall         = (state_q != IDLE);
    assign mem_req       = (state_q == BUSY);
    assign MEM_WB        = mem_wb_q;
    assign pcsrc         = pcsrc_q;
    assign branch_target = branch_target_q;
    assign align_err     = align_err_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_obsidian_memory_stage.sv
// Scoreboard bench for obsidian_memory_stage: driver pushes expected events, a negedge monitor
// classifies DUT events from stall transitions and pops/compares them.
module tb_obsidian_memory_stage;

    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [106:0] EX_MEM = '0;
    logic [70:0]  MEM_WB;
    logic         stall;
    logic         pcsrc;
    logic [31:0]  branch_target;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic         align_err;
    logic         timeout_err;

`ifndef OBSIDIAN_MEM_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

    always #5 clk = ~clk;

    obsidian_memory_stage #(.MEM_TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .EX_MEM        (EX_MEM),
        .MEM_WB        (MEM_WB),
        .stall         (stall),
        .pcsrc         (pcsrc),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .align_err     (align_err)
`ifdef OBSIDIAN_MEM_TIMEOUT_EN
       ,.timeout_err   (timeout_err)
`endif
    );

    // kind: 0 = idle-sampled result, 1 = memory access start, 2 = memory access done
    typedef struct {
        int          kind;
        logic [70:0] wb;
        logic        pcsrc;
        logic [31:0] tgt;
        logic        align;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall_cycles;
        int          req_cycles;
        int          tmo;
    } item_t;

    item_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic void chk(input string nm, input logic [70:0] act, input logic [70:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [106:0] mk(input logic rw, input logic mtr, input logic br,
                                        input logic mr, input logic mw, input logic [31:0] tgt,
                                        input logic z, input logic [31:0] alu,
                                        input logic [31:0] sd, input logic [4:0] rd);
        return {rw, mtr, br, mr, mw, tgt, z, alu, sd, rd};
    endfunction

    // filler presented while stalled: always a taken branch so an unwanted sample shows up
    function automatic logic [106:0] junk();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        t[104] = 1'b1;
        t[69]  = 1'b1;
        return t[106:0];
    endfunction

    // Called just after a negedge; returns just after a negedge.
    task automatic do_txn(input logic [106:0] ex, input int delay, input logic [31:0] rdata,
                          input bit abort_rst);
        logic        rw, mtr, br, mr, mw, z;
        logic [31:0] tgt, alu, sd;
        logic [4:0]  rd;
        logic        is_mem, mis, tmo_hit;
        int          nrdy;
        item_t       it;
        {rw, mtr, br, mr, mw, tgt, z, alu, sd, rd} = ex;
        is_mem = mr | mw;
        mis    = is_mem && (alu[1:0] != 2'b00);
        it       = '{default: 0};
        it.pcsrc = br & z;
        it.tgt   = tgt;
        EX_MEM    = ex;
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
        if (!is_mem || mis) begin
            it.kind  = 0;
            it.wb    = {rw & ~mis, mtr, 32'h0, alu, rd};
            it.align = mis;
            sb.push_back(it);
            @(negedge clk);
        end else begin
            tmo_hit = 1'b0;
            nrdy    = delay;
`ifdef OBSIDIAN_MEM_TIMEOUT_EN
            if (delay >= TMO) begin
                tmo_hit = 1'b1;
                nrdy    = TMO;
            end
`endif
            it.kind         = 1;
            it.wr           = mw;
            it.addr         = alu;
            it.wdata        = sd;
            it.stall_cycles = tmo_hit ? nrdy + 1 : nrdy + 2;
            it.req_cycles   = tmo_hit ? nrdy : nrdy + 1;
            it.tmo          = tmo_hit ? 1 : 0;
            sb.push_back(it);
            @(negedge clk);
            if (abort_rst) begin
                EX_MEM    = junk();
                mem_ready = 1'b0;
                @(negedge clk);
                reset     = 1'b1;
                mem_ready = 1'b1;
                @(negedge clk);
                chk("rst_busy_mem_req", 71'(mem_req), 71'(0));
                chk("rst_busy_stall", 71'(stall), 71'(0));
                chk("rst_busy_mem_wb", MEM_WB, 71'(0));
                chk("rst_busy_pcsrc", 71'(pcsrc), 71'(0));
                chk("rst_busy_align", 71'(align_err), 71'(0));
                reset     = 1'b0;
                mem_ready = 1'b0;
                return;
            end
            repeat (nrdy) begin
                EX_MEM    = junk();
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                @(negedge clk);
            end
            if (!tmo_hit) begin
                EX_MEM    = junk();
                mem_ready = 1'b1;
                mem_rdata = rdata;
                @(negedge clk);
            end
            EX_MEM    = junk();
            mem_ready = 1'($urandom);
            mem_rdata = $urandom;
            it.kind   = 2;
            it.pcsrc  = 1'b0;
            it.wb     = {rw & ~tmo_hit, mtr,
                         tmo_hit ? 32'hDEAD_BEEF : (mw ? 32'h0 : rdata), alu, rd};
            sb.push_back(it);
            @(negedge clk);
        end
    endtask

    // ---------------- monitor ----------------
    logic  rst_at_edge = 1'b1;
    logic  prev_stall  = 1'b0;
    item_t cur;
    item_t got;
    int    ev_kind;
    int    st_cnt = 0;
    int    rq_cnt = 0;
    int    to_cnt = 0;

    always @(posedge clk) rst_at_edge <= reset;

    always @(negedge clk) begin
        if (rst_at_edge) begin
            prev_stall = 1'b0;
        end else if (prev_stall && stall) begin
            chk("busy_regwrite", 71'(MEM_WB[70]), 71'(0));
            chk("busy_pcsrc", 71'(pcsrc), 71'(0));
            chk("busy_align", 71'(align_err), 71'(0));
            if (mem_req) begin
                chk("busy_addr", 71'(mem_addr), 71'(cur.addr));
                chk("busy_we", 71'(mem_we), 71'(cur.wr));
            end
            st_cnt = st_cnt + 1;
            rq_cnt = rq_cnt + (mem_req ? 1 : 0);
            to_cnt = to_cnt + (timeout_err ? 1 : 0);
        end else begin
            ev_kind = prev_stall ? 2 : (stall ? 1 : 0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: DUT event kind %0d, expected no event (t=%0t)", ev_kind, $time);
            end else begin
                got = sb.pop_front();
                chk("event_kind", 71'(ev_kind), 71'(got.kind));
                if (ev_kind == got.kind) begin
                    case (got.kind)
                        0: begin
                            chk("idle_mem_wb", MEM_WB, got.wb);
                            chk("idle_pcsrc", 71'(pcsrc), 71'(got.pcsrc));
                            chk("idle_target", 71'(branch_target), 71'(got.tgt));
                            chk("idle_align", 71'(align_err), 71'(got.align));
                            chk("idle_mem_req", 71'(mem_req), 71'(0));
                            chk("idle_timeout_err", 71'(timeout_err), 71'(0));
                        end
                        1: begin
                            chk("bubble_regwrite", 71'(MEM_WB[70]), 71'(0));
                            chk("start_pcsrc", 71'(pcsrc), 71'(got.pcsrc));
                            chk("start_target", 71'(branch_target), 71'(got.tgt));
                            chk("start_align", 71'(align_err), 71'(0));
                            chk("start_mem_req", 71'(mem_req), 71'(1));
                            chk("start_mem_we", 71'(mem_we), 71'(got.wr));
                            chk("start_mem_addr", 71'(mem_addr), 71'(got.addr));
                            if (got.wr)
                                chk("start_mem_wdata", 71'(mem_wdata), 71'(got.wdata));
                            cur    = got;
                            st_cnt = 1;
                            rq_cnt = mem_req ? 1 : 0;
                            to_cnt = timeout_err ? 1 : 0;
                        end
                        default: begin
                            chk("done_mem_wb", MEM_WB, got.wb);
                            chk("done_pcsrc", 71'(pcsrc), 71'(0));
                            chk("done_stall_cycles", 71'(st_cnt), 71'(got.stall_cycles));
                            chk("done_req_cycles", 71'(rq_cnt), 71'(got.req_cycles));
                            chk("done_timeout_pulses", 71'(to_cnt), 71'(got.tmo));
                            chk("done_timeout_err", 71'(timeout_err), 71'(0));
                        end
                    endcase
                end
            end
        end
        if (!rst_at_edge) prev_stall = stall;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] t;
        logic [106:0] ex;
        int           r;

        EX_MEM    = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234, 1'b1, 32'h40, 32'h77, 5'd3);
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("rst_mem_wb", MEM_WB, 71'(0));
        chk("rst_stall", 71'(stall), 71'(0));
        chk("rst_pcsrc", 71'(pcsrc), 71'(0));
        chk("rst_target", 71'(branch_target), 71'(0));
        chk("rst_mem_req", 71'(mem_req), 71'(0));
        chk("rst_mem_we", 71'(mem_we), 71'(0));
        chk("rst_mem_addr", 71'(mem_addr), 71'(0));
        chk("rst_mem_wdata", 71'(mem_wdata), 71'(0));
        chk("rst_align", 71'(align_err), 71'(0));
        chk("rst_timeout_err", 71'(timeout_err), 71'(0));
        reset = 1'b0;

        do_txn(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h12, 32'h0, 5'd5), 0, 32'h0, 1'b0);
        do_txn(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h40, 32'h0, 5'd9), 2, 32'hCAFE_0001, 1'b0);
        do_txn(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h8, 32'h55, 5'd3), 1, 32'h1111_2222, 1'b0);
        do_txn(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h10, 32'hAA, 5'd7), 0, 32'h1234_5678, 1'b0);
        do_txn(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h42, 32'h0, 5'd4), 0, 32'h0, 1'b0);
        do_txn(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 32'h20, 32'h0, 5'd0), 0, 32'h0, 1'b0);
        do_txn(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 1'b0, 32'h24, 32'h0, 5'd0), 0, 32'h0, 1'b0);
        do_txn(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h80, 32'h0, 5'd12), 10, 32'hABCD_0000, 1'b0);

        for (int n = 0; n < 300; n++) begin
            t = {$urandom, $urandom, $urandom, $urandom};
            r = int'($urandom_range(0, 9));
            t[104] = 1'($urandom);
            t[69]  = 1'($urandom);
            if (r < 4) begin
                t[103:102] = 2'b00;
            end else begin
                t[103:102] = 2'($urandom_range(1, 3));
                if (r < 9) t[38:37] = 2'b00;
                else       t[38:37] = 2'($urandom_range(1, 3));
            end
            ex = t[106:0];
            do_txn(ex, int'($urandom_range(0, 6)), $urandom, 1'b0);
        end

        do_txn(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'hC0, 32'h0, 5'd2), 3, 32'h0, 1'b1);
        do_txn(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h33, 32'h0, 5'd6), 0, 32'h0, 1'b0);
        do_txn(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'hC4, 32'h0, 5'd8), 0, 32'h5A5A_A5A5, 1'b0);
        do_txn(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44, 32'h0, 5'd1), 0, 32'h0, 1'b0);

        #1;
        chk("sb_drained", 71'(sb.size()), 71'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
